// File: rtl/computing_core_pkg.sv
// -----------------------------------------------------------------------------
// computing_core_pkg
// Shared constants and types for the 3x3, four-filter convolution core.
//   NUM_FILTERS  : number of kernels applied to every window
//   KERNEL_TAPS  : taps per kernel (3x3, row-major, k = 3*r + c)
//   KERNEL_DIM   : rows/columns of one kernel and one window
//   WIDTH_DEF    : default width of weights, activations and partial sums
//   taps_t       : one filter's nine taps at the default width
// -----------------------------------------------------------------------------
package computing_core_pkg;

    localparam int NUM_FILTERS = 4;
    localparam int KERNEL_TAPS = 9;
    localparam int KERNEL_DIM  = 3;
    localparam int WIDTH_DEF   = 8;

    typedef logic [KERNEL_TAPS-1:0][WIDTH_DEF-1:0] taps_t;

endpackage

// File: rtl/computing_core_dot9_unit.sv
// -----------------------------------------------------------------------------
// dot9_unit
// Two-stage 9-tap unsigned dot product for one filter.
//   clk, rst  : clock, synchronous active-high reset
//   in_vld    : window on acts is valid this cycle
//   taps      : nine WIDTH-bit weights, tap k at [k*WIDTH +: WIDTH]
//   acts      : nine WIDTH-bit activations, same packing
//   psum      : registered sum modulo 2^WIDTH (holds when not valid)
//   psum_vld  : psum carries a fresh result
// Stage 1 registers the nine full-width products, stage 2 registers the
// truncated sum.
// -----------------------------------------------------------------------------
module dot9_unit
    import computing_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic [KERNEL_TAPS*WIDTH-1:0] taps,
    input  logic [KERNEL_TAPS*WIDTH-1:0] acts,
    output logic [WIDTH-1:0]             psum,
    output logic                         psum_vld
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int SUM_W  = 2 * WIDTH + 4;

    logic [KERNEL_TAPS-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                               vld1_q, vld1_d;
    logic [WIDTH-1:0]                   psum_q, psum_d;
    logic                               vld2_q, vld2_d;
    logic [SUM_W-1:0]                   sum;
    logic                               unused_sum_hi;

    // Products only update on a valid window so idle cycles cost no toggles.
    for (genvar gi = 0; gi < KERNEL_TAPS; gi++) begin : g_prod
        assign prod_d[gi] = in_vld
            ? PROD_W'(taps[gi*WIDTH +: WIDTH]) * PROD_W'(acts[gi*WIDTH +: WIDTH])
            : prod_q[gi];
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            sum = sum + SUM_W'(prod_q[k]);
        end
        vld1_d = in_vld;
        vld2_d = vld1_q;
        // Output wraps modulo 2^WIDTH; value holds between valid results.
        psum_d = vld1_q ? sum[WIDTH-1:0] : psum_q;
    end

    // Upper sum bits are dropped by design (no saturation).
    assign unused_sum_hi = ^sum[SUM_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            vld1_q <= 1'b0;
            psum_q <= '0;
            vld2_q <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld1_q <= vld1_d;
            psum_q <= psum_d;
            vld2_q <= vld2_d;
        end
    end

    assign psum     = psum_q;
    assign psum_vld = vld2_q;

endmodule

// File: rtl/computing_core.sv
// -----------------------------------------------------------------------------
// computing_core
// Applies four 3x3 kernels of unsigned weights to one 3x3 activation window
// per clock and emits four WIDTH-bit partial sums two edges later.
//   clk, rst             : clock, synchronous active-high reset
//   activate_ready       : activate0..2 carry a valid window this cycle
//   weight_load          : weight0..3 carry one tap per filter this cycle
//   activate0..2         : window rows; column 0 in the top WIDTH bits
//   weight0..3           : current tap for filter 0..3
//   weight_load_done     : combinational, high while the 9th tap is presented
//   out_psum0..3         : registered partial sums of filter 0..3
//   out_psum_vld         : out_psum0..3 are valid
// -----------------------------------------------------------------------------
module computing_core
    import computing_core_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  activate_ready,
    input  logic                  weight_load,
    input  logic [3*WIDTH-1:0]    activate0,
    input  logic [3*WIDTH-1:0]    activate1,
    input  logic [3*WIDTH-1:0]    activate2,
    input  logic [WIDTH-1:0]      weight0,
    input  logic [WIDTH-1:0]      weight1,
    input  logic [WIDTH-1:0]      weight2,
    input  logic [WIDTH-1:0]      weight3,
    output logic                  weight_load_done,
    output logic [WIDTH-1:0]      out_psum0,
    output logic [WIDTH-1:0]      out_psum1,
    output logic [WIDTH-1:0]      out_psum2,
    output logic [WIDTH-1:0]      out_psum3,
    output logic                  out_psum_vld
);

    localparam logic [3:0] LAST_TAP = 4'(KERNEL_TAPS - 1);

    logic [3:0] cnt_q, cnt_d;
    logic [NUM_FILTERS-1:0][KERNEL_TAPS-1:0][WIDTH-1:0] w_q, w_d;
    logic [NUM_FILTERS-1:0][WIDTH-1:0]                  weight_in;
    logic [KERNEL_DIM-1:0][KERNEL_DIM*WIDTH-1:0]        rows;
    logic [KERNEL_TAPS*WIDTH-1:0]                       acts_flat;
    logic [NUM_FILTERS-1:0][WIDTH-1:0]                  psum_arr;
    logic [NUM_FILTERS-1:0]                             vld_vec;

    assign weight_in = {weight3, weight2, weight1, weight0};
    assign rows      = {activate2, activate1, activate0};

    // Reorder the row-packed window into tap order k = 3*r + c.
    for (genvar gr = 0; gr < KERNEL_DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < KERNEL_DIM; gc++) begin : g_col
            assign acts_flat[(KERNEL_DIM*gr + gc)*WIDTH +: WIDTH] =
                rows[gr][(KERNEL_DIM-gc)*WIDTH-1 -: WIDTH];
        end
    end

    // Tap cnt of every filter captures its weight input during a load.
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_wfilt
        for (genvar gk = 0; gk < KERNEL_TAPS; gk++) begin : g_wtap
            assign w_d[gi][gk] = (weight_load && cnt_q == 4'(gk)) ? weight_in[gi]
                                                                  : w_q[gi][gk];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (weight_load) begin
            cnt_d = (cnt_q == LAST_TAP) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            w_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            w_q   <= w_d;
        end
    end

    assign weight_load_done = weight_load && (cnt_q == LAST_TAP) && !rst;

    // Each unit samples w_q before this edge's capture, so a window that
    // coincides with a load sees the previously stored taps.
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_dot
        dot9_unit #(.WIDTH(WIDTH)) u_dot9 (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (activate_ready),
            .taps     (w_q[gi]),
            .acts     (acts_flat),
            .psum     (psum_arr[gi]),
            .psum_vld (vld_vec[gi])
        );
    end

    assign out_psum0    = psum_arr[0];
    assign out_psum1    = psum_arr[1];
    assign out_psum2    = psum_arr[2];
    assign out_psum3    = psum_arr[3];
    assign out_psum_vld = &vld_vec;

endmodule

// File: tb/tb_computing_core.sv
// Directed bench for computing_core: reset, load, compute, wrap, overlap and
// mid-operation reset, with hand-computed expected values.
module tb_computing_core;
    import computing_core_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           activate_ready;
    logic           weight_load;
    logic [3*W-1:0] activate0, activate1, activate2;
    logic [W-1:0]   weight0, weight1, weight2, weight3;
    logic           weight_load_done;
    logic [W-1:0]   out_psum0, out_psum1, out_psum2, out_psum3;
    logic           out_psum_vld;

    int n_chk  = 0;
    int n_pass = 0;

    computing_core #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .activate_ready   (activate_ready),
        .weight_load      (weight_load),
        .activate0        (activate0),
        .activate1        (activate1),
        .activate2        (activate2),
        .weight0          (weight0),
        .weight1          (weight1),
        .weight2          (weight2),
        .weight3          (weight3),
        .weight_load_done (weight_load_done),
        .out_psum0        (out_psum0),
        .out_psum1        (out_psum1),
        .out_psum2        (out_psum2),
        .out_psum3        (out_psum3),
        .out_psum_vld     (out_psum_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uniform_window(input logic [W-1:0] v);
        activate0 = {v, v, v};
        activate1 = {v, v, v};
        activate2 = {v, v, v};
    endtask

    // Window with row r, column c = ai + 8r + c.
    task automatic set_ramp_window(input int ai);
        logic [W-1:0] b;
        b = W'(ai);
        activate0 = {b,        b + 8'd1,  b + 8'd2};
        activate1 = {b + 8'd8, b + 8'd9,  b + 8'd10};
        activate2 = {b + 8'd16, b + 8'd17, b + 8'd18};
    endtask

    task automatic check_psums(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3);
        check({tag, ".psum0"}, 32'(out_psum0), 32'(e0));
        check({tag, ".psum1"}, 32'(out_psum1), 32'(e1));
        check({tag, ".psum2"}, 32'(out_psum2), 32'(e2));
        check({tag, ".psum3"}, 32'(out_psum3), 32'(e3));
    endtask

    // Nine-cycle load; done must be high in the 9th cycle only.
    task automatic load_all(input string tag, input taps_t w0, input taps_t w1,
                            input taps_t w2, input taps_t w3);
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            weight_load = 1'b1;
            weight0 = w0[i];
            weight1 = w1[i];
            weight2 = w2[i];
            weight3 = w3[i];
            #1;
            check($sformatf("%s.done[%0d]", tag, i), 32'(weight_load_done), 32'(i == 8));
            step();
        end
        weight_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        taps_t ramp, zeros, ones, fives, tw[NUM_FILTERS];
        logic [W-1:0] exp_ramp[3];

        for (int k = 0; k < KERNEL_TAPS; k++) begin
            ramp[k]  = W'(k);
            zeros[k] = '0;
            ones[k]  = 8'd1;
            fives[k] = 8'd5;
        end
        exp_ramp[0] = 8'd218;
        exp_ramp[1] = 8'd254;
        exp_ramp[2] = 8'd34;

        // ---------------- reset with toggling inputs ----------------
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            weight_load    = 1'b1;
            activate_ready = i[0];
            weight0 = W'($urandom); weight1 = W'($urandom);
            weight2 = W'($urandom); weight3 = W'($urandom);
            set_uniform_window(W'($urandom));
            #1;
            check("rst.done", 32'(weight_load_done), 32'd0);
            step();
            check("rst.vld", 32'(out_psum_vld), 32'd0);
            check_psums("rst", 8'd0, 8'd0, 8'd0, 8'd0);
        end
        rst = 1'b0;
        weight_load = 1'b0;
        activate_ready = 1'b0;
        set_uniform_window(8'd0);

        // ---------------- weight load: filter 0 = 0..8 ----------------
        load_all("load", ramp, zeros, zeros, zeros);

        // ---------------- compute: three back-to-back windows ----------------
        for (int s = 0; s < 5; s++) begin
            if (s < 3) begin
                activate_ready = 1'b1;
                set_ramp_window(s);
            end else begin
                activate_ready = 1'b0;
            end
            step();
            check($sformatf("cmp.vld[%0d]", s), 32'(out_psum_vld), 32'(s >= 1 && s <= 3));
            if (s >= 1)
                check_psums($sformatf("cmp[%0d]", s), exp_ramp[(s > 3) ? 2 : s - 1],
                            8'd0, 8'd0, 8'd0);
        end

        // ---------------- wrap-around: 9 * 1 * 255 = 2295 -> 247 ----------------
        load_all("wload", ones, ones, ones, ones);
        activate_ready = 1'b1;
        set_uniform_window(8'd255);
        step();
        activate_ready = 1'b0;
        step();
        check("wrap.vld", 32'(out_psum_vld), 32'd1);
        check_psums("wrap", 8'd247, 8'd247, 8'd247, 8'd247);

        // ---------------- overlap: load tap 0 = 5 while sampling ----------------
        // Window A[0]=10, rest 1: old taps -> 18, new tap0=5 -> 58.
        weight_load = 1'b1;
        weight0 = 8'd5; weight1 = 8'd5; weight2 = 8'd5; weight3 = 8'd5;
        activate_ready = 1'b1;
        activate0 = {8'd10, 8'd1, 8'd1};
        activate1 = {8'd1, 8'd1, 8'd1};
        activate2 = {8'd1, 8'd1, 8'd1};
        step();
        weight_load = 1'b0;
        step();
        activate_ready = 1'b0;
        check("ovl.old.vld", 32'(out_psum_vld), 32'd1);
        check_psums("ovl.old", 8'd18, 8'd18, 8'd18, 8'd18);
        step();
        check("ovl.new.vld", 32'(out_psum_vld), 32'd1);
        check_psums("ovl.new", 8'd58, 8'd58, 8'd58, 8'd58);

        // ---------------- mid-operation reset ----------------
        weight_load = 1'b1;
        activate_ready = 1'b1;
        set_uniform_window(8'd7);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("mrst.done", 32'(weight_load_done), 32'd0);
            step();
            check("mrst.vld", 32'(out_psum_vld), 32'd0);
        end
        rst = 1'b0;
        weight_load = 1'b0;
        activate_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("mrst.flush.vld", 32'(out_psum_vld), 32'd0);
        end
        check_psums("mrst", 8'd0, 8'd0, 8'd0, 8'd0);

        // Fresh load must start at tap 0: filter j taps = j+1.
        for (int j = 0; j < NUM_FILTERS; j++)
            for (int k = 0; k < KERNEL_TAPS; k++)
                tw[j][k] = W'(j + 1);
        load_all("rload", tw[0], tw[1], tw[2], tw[3]);
        activate_ready = 1'b1;
        set_uniform_window(8'd3);
        step();
        activate_ready = 1'b0;
        step();
        check("rload.vld", 32'(out_psum_vld), 32'd1);
        check_psums("rload", 8'd27, 8'd54, 8'd81, 8'd108);
        step();
        check("rload.idle.vld", 32'(out_psum_vld), 32'd0);
        check_psums("rload.hold", 8'd27, 8'd54, 8'd81, 8'd108);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
